// File: rtl/bpu_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bpu_port_arbiter_pkg
// Description : Shared fetch-stage definitions for the branch-prediction port
//               arbiter. Holds the branch opcodes, the instruction and address
//               widths, the port-command state enum and the packed update
//               entry stored in the update FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package bpu_port_arbiter_pkg;

    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] B_inst = 7'b1100011;

    localparam int INST_W = 24;
    localparam int ADDR_W = 32;

    // State names the command driven on the shared port in the current cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        UPDATE = 2'd2
    } bpu_state_e;

    typedef struct packed {
        logic              taken;
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] taddr;
    } upd_entry_t;

endpackage
`default_nettype wire

// File: rtl/bpu_port_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bpu_upd_fifo
// Description : Resolution-update FIFO for the branch-prediction port arbiter.
//               Circular buffer with wrap-around pointers and an occupancy
//               counter. Also reports, per storage slot, whether a valid entry
//               carries the given 10-bit BTB/LHT index.
// Revision    : 1.0 - initial release
// Ports       : clk, rst          clock, asynchronous active-high reset
//               push, push_data   write one entry (caller guarantees !full)
//               pop               drop the head entry (caller guarantees !empty)
//               head              current head entry
//               full, empty,count occupancy status
//               match_idx, match  index to compare / per-slot hit vector
// ============================================================================
module bpu_upd_fifo
    import bpu_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  upd_entry_t                 push_data,
    input  logic                       pop,
    output upd_entry_t                 head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    input  logic [9:0]                 match_idx,
    output logic [DEPTH-1:0]           match
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    upd_entry_t           r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    // Storage carries no reset; validity is tracked by pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign full  = (r_count == c_CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

    // A slot is live when its distance from the read pointer is below the
    // occupancy; only live slots may report an index hit.
    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        logic [c_PTR_W-1:0] w_offset;
        assign w_offset = c_PTR_W'(i) - r_rd_ptr;
        assign match[i] = ({1'b0, w_offset} < r_count) &&
                          (r_mem[i].inst[9:0] == match_idx);
    end

endmodule
`default_nettype wire

// File: rtl/bpu_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bpu_port_arbiter
// Description : Sequencer for the single shared BTB / branch-predictor port.
//               Every cycle one command is driven: a fetch lookup (read), a
//               buffered execute-stage resolution update (write), or idle.
//               Updates are queued in bpu_upd_fifo; lookup starvation of the
//               update queue is bounded by STARVE_MAX.
// Revision    : 1.0 - initial release
// Config      : BPU_ARB_RAW_EN - when defined, a lookup whose index matches a
//               queued update is held off until that update has drained.
// Ports       : clk, rst                  clock, async active-high reset
//               lk_req/lk_cond/lk_inst    lookup request from fetch
//               lk_gnt (comb), lk_done    lookup accept / data-valid
//               up_valid/taken/inst/taddr resolution update from execute
//               up_ready                  update FIFO not full
//               read_write, buffer_select, branch_predictor_select,
//               br_inst, LHT_index, br_taddr_exe, prediction_valid_exe
//                                         registered port command
//               q_count                   update FIFO occupancy
// ============================================================================
module bpu_port_arbiter
    import bpu_port_arbiter_pkg::*;
#(
    parameter int UPD_DEPTH  = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         lk_req,
    input  logic                         lk_cond,
    input  logic [INST_W-1:0]            lk_inst,
    output logic                         lk_gnt,
    output logic                         lk_done,
    input  logic                         up_valid,
    input  logic                         up_taken,
    input  logic [INST_W-1:0]            up_inst,
    input  logic [ADDR_W-1:0]            up_taddr,
    output logic                         up_ready,
    output logic                         read_write,
    output logic                         buffer_select,
    output logic                         branch_predictor_select,
    output logic [INST_W-1:0]            br_inst,
    output logic [3:0]                   LHT_index,
    output logic [ADDR_W-1:0]            br_taddr_exe,
    output logic                         prediction_valid_exe,
    output logic [$clog2(UPD_DEPTH):0]   q_count
);

    localparam int c_STV_W = $clog2(STARVE_MAX + 1);

    bpu_state_e             r_state;
    bpu_state_e             w_next_state;
    logic [c_STV_W-1:0]     r_starve;
    logic                   w_starved;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_raw_hit;
    upd_entry_t             w_head;
    upd_entry_t             w_push_data;
    logic [UPD_DEPTH-1:0]   w_match;

    assign w_push_data = '{taken: up_taken, inst: up_inst, taddr: up_taddr};
    assign w_push      = up_valid && up_ready;
    assign w_pop       = (w_next_state == UPDATE);

    bpu_upd_fifo #(
        .DEPTH     (UPD_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (q_count),
        .match_idx (lk_inst[9:0]),
        .match     (w_match)
    );

`ifdef BPU_ARB_RAW_EN
    // Pending write to the same BTB/LHT slot: drain before reading it.
    assign w_raw_hit = lk_req && (|w_match);
`else
    logic w_unused_match;
    assign w_unused_match = ^w_match;
    assign w_raw_hit      = 1'b0;
`endif

    assign w_starved = (r_starve == c_STV_W'(STARVE_MAX));

    // Next-state choice depends only on queue status and the request; the
    // current command never constrains the next one.
    always_comb begin
        w_next_state = IDLE;
        if (!w_fifo_empty && (w_fifo_full || w_starved || !lk_req || w_raw_hit)) begin
            w_next_state = UPDATE;
        end else if (lk_req) begin
            w_next_state = LOOKUP;
        end
    end

    // No lookup is accepted while reset is held.
    assign lk_gnt    = lk_req && (w_next_state == LOOKUP) && !rst;
    assign up_ready  = !w_fifo_full;
    assign lk_done   = (r_state == LOOKUP);
    assign LHT_index = br_inst[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_starve <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_fifo_empty || (w_next_state == UPDATE)) begin
                r_starve <= '0;
            end else if (!w_starved) begin
                r_starve <= r_starve + c_STV_W'(1);
            end
        end
    end

    // Port command register: loaded with the command chosen at this edge.
    // br_inst and br_taddr_exe hold their last value while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_write              <= 1'b1;
            buffer_select           <= 1'b0;
            branch_predictor_select <= 1'b0;
            br_inst                 <= '0;
            br_taddr_exe            <= '0;
            prediction_valid_exe    <= 1'b0;
        end else begin
            case (w_next_state)
                LOOKUP: begin
                    read_write              <= 1'b1;
                    buffer_select           <= 1'b1;
                    branch_predictor_select <= lk_cond;
                    br_inst                 <= lk_inst;
                    prediction_valid_exe    <= 1'b0;
                end
                UPDATE: begin
                    read_write              <= 1'b0;
                    buffer_select           <= 1'b1;
                    branch_predictor_select <= 1'b1;
                    br_inst                 <= w_head.inst;
                    br_taddr_exe            <= w_head.taddr;
                    prediction_valid_exe    <= w_head.taken;
                end
                default: begin
                    read_write              <= 1'b1;
                    buffer_select           <= 1'b0;
                    branch_predictor_select <= 1'b0;
                    prediction_valid_exe    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bpu_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bpu_port_arbiter
// Description : Self-checking bench for bpu_port_arbiter. A queue-based
//               reference model tracks pending updates and the starvation
//               count, predicts each cycle's grant and port command, and is
//               compared against the DUT under directed and random stimulus.
// Revision    : 1.0 - initial release
// Config      : honours BPU_ARB_RAW_EN in the reference model.
// ============================================================================
module tb_bpu_port_arbiter;

    localparam int c_DEPTH  = 4;
    localparam int c_STARVE = 8;

    typedef struct {
        logic        taken;
        logic [23:0] inst;
        logic [31:0] taddr;
    } ref_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        lk_req, lk_cond;
    logic [23:0] lk_inst;
    logic        lk_gnt, lk_done;
    logic        up_valid, up_taken;
    logic [23:0] up_inst;
    logic [31:0] up_taddr;
    logic        up_ready;
    logic        read_write, buffer_select, branch_predictor_select;
    logic [23:0] br_inst;
    logic [3:0]  LHT_index;
    logic [31:0] br_taddr_exe;
    logic        prediction_valid_exe;
    logic [2:0]  q_count;

    bpu_port_arbiter #(
        .UPD_DEPTH               (c_DEPTH),
        .STARVE_MAX              (c_STARVE)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .lk_req                  (lk_req),
        .lk_cond                 (lk_cond),
        .lk_inst                 (lk_inst),
        .lk_gnt                  (lk_gnt),
        .lk_done                 (lk_done),
        .up_valid                (up_valid),
        .up_taken                (up_taken),
        .up_inst                 (up_inst),
        .up_taddr                (up_taddr),
        .up_ready                (up_ready),
        .read_write              (read_write),
        .buffer_select           (buffer_select),
        .branch_predictor_select (branch_predictor_select),
        .br_inst                 (br_inst),
        .LHT_index               (LHT_index),
        .br_taddr_exe            (br_taddr_exe),
        .prediction_valid_exe    (prediction_valid_exe),
        .q_count                 (q_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    ref_t        mq[$];
    int          m_starve = 0;
    int          e_kind   = 0;     // 0 idle, 1 lookup, 2 update
    logic [23:0] e_br     = '0;
    logic [31:0] e_taddr  = '0;
    logic        e_pve    = 1'b0;
    logic        e_bps    = 1'b0;
    logic        m_gnt    = 1'b0;
    logic        obs_gnt  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] rnd_inst();
        logic [23:0] v;
        v       = 24'($urandom);
        v[9:0]  = 10'($urandom_range(0, 7));
        return v;
    endfunction

    // One clock cycle: inputs are already driven. Checks the combinational
    // outputs mid-cycle, advances the model at the edge, then checks the
    // registered port command.
    task automatic cycle();
        ref_t h;
        bit   hit, sel_upd, sel_lk, push;
        int   qn;
        #1;
        hit = 0;
`ifdef BPU_ARB_RAW_EN
        if (lk_req) foreach (mq[i]) if (mq[i].inst[9:0] == lk_inst[9:0]) hit = 1;
`endif
        qn      = mq.size();
        sel_upd = (qn > 0) && (qn == c_DEPTH || m_starve >= c_STARVE || !lk_req || hit);
        sel_lk  = !sel_upd && lk_req;
        push    = up_valid && (qn < c_DEPTH);
        obs_gnt = lk_gnt;
        check("lk_gnt", 32'(lk_gnt), 32'(sel_lk));
        check("up_ready", 32'(up_ready), 32'(qn < c_DEPTH));
        check("q_count", 32'(q_count), 32'(qn));
        @(posedge clk);
        if (sel_upd) begin
            h       = mq.pop_front();
            e_kind  = 2;
            e_br    = h.inst;
            e_taddr = h.taddr;
            e_pve   = h.taken;
            e_bps   = 1'b1;
        end else if (sel_lk) begin
            e_kind = 1;
            e_br   = lk_inst;
            e_bps  = lk_cond;
        end else begin
            e_kind = 0;
            e_bps  = 1'b0;
        end
        if (qn == 0 || sel_upd) m_starve = 0;
        else if (m_starve < c_STARVE) m_starve++;
        if (push) mq.push_back('{up_taken, up_inst, up_taddr});
        m_gnt = sel_lk;
        #1;
        check("lk_done", 32'(lk_done), 32'(e_kind == 1));
        check("read_write", 32'(read_write), 32'(e_kind != 2));
        check("buffer_select", 32'(buffer_select), 32'(e_kind != 0));
        check("bp_select", 32'(branch_predictor_select), 32'(e_bps));
        if (e_kind != 0) begin
            check("br_inst", 32'(br_inst), 32'(e_br));
            check("LHT_index", 32'(LHT_index), 32'(e_br[3:0]));
        end
        if (e_kind == 2) begin
            check("br_taddr_exe", br_taddr_exe, e_taddr);
            check("pred_valid_exe", 32'(prediction_valid_exe), 32'(e_pve));
        end
    endtask

    // Asserts reset away from the clock edge; all outputs must clear at once.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_lk_gnt", 32'(lk_gnt), 32'd0);
        check("rst_q_count", 32'(q_count), 32'd0);
        check("rst_up_ready", 32'(up_ready), 32'd1);
        check("rst_read_write", 32'(read_write), 32'd1);
        check("rst_buffer_select", 32'(buffer_select), 32'd0);
        check("rst_bp_select", 32'(branch_predictor_select), 32'd0);
        check("rst_pred_valid", 32'(prediction_valid_exe), 32'd0);
        check("rst_lk_done", 32'(lk_done), 32'd0);
        check("rst_br_inst", 32'(br_inst), 32'd0);
        check("rst_LHT_index", 32'(LHT_index), 32'd0);
        check("rst_br_taddr", br_taddr_exe, 32'd0);
        lk_req   = 1'b0;
        up_valid = 1'b0;
        mq.delete();
        m_starve = 0;
        e_kind   = 0;
        e_bps    = 1'b0;
        m_gnt    = 1'b0;
        @(posedge clk);
        #1;
        check("rst_hold_read_write", 32'(read_write), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int denied;
        int p_req, p_up;
        rst = 1'b0; lk_req = 1'b0; lk_cond = 1'b0; lk_inst = '0;
        up_valid = 1'b0; up_taken = 1'b0; up_inst = '0; up_taddr = '0;
        #2;
        do_reset();

        // First lookup with an empty queue.
        lk_req = 1'b1; lk_cond = 1'b0; lk_inst = 24'h00ABC3;
        cycle();
        check("first_gnt", 32'(obs_gnt), 32'd1);
        check("first_done", 32'(lk_done), 32'd1);
        check("first_rw", 32'(read_write), 32'd1);
        check("first_lht", 32'(LHT_index), 32'h3);
        check("first_bs", 32'(buffer_select), 32'd1);
        check("first_bps", 32'(branch_predictor_select), 32'd0);

        // Single update with no lookup pending.
        lk_req = 1'b0;
        up_valid = 1'b1; up_taken = 1'b1; up_inst = 24'h000021; up_taddr = 32'h40;
        cycle();
        up_valid = 1'b0;
        cycle();
        check("upd_rw", 32'(read_write), 32'd0);
        check("upd_taddr", br_taddr_exe, 32'h40);
        check("upd_pve", 32'(prediction_valid_exe), 32'd1);
        check("upd_qcount", 32'(q_count), 32'd0);

        // Starvation bound: one queued update against a continuous request.
        lk_req = 1'b1; lk_inst = 24'h0003FF;
        up_valid = 1'b1; up_taken = 1'b0; up_inst = 24'h000020; up_taddr = 32'h80;
        cycle();
        up_valid = 1'b0;
        denied = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (!obs_gnt) break;
            denied++;
        end
        check("starve_denied", 32'(denied), 32'(c_STARVE));
        check("starve_rw", 32'(read_write), 32'd0);

        // Fill the queue while the lookup stream continues.
        for (int k = 0; k < c_DEPTH; k++) begin
            up_valid = 1'b1; up_inst = 24'h000030 + 24'(k); up_taddr = 32'h100 + 32'(k);
            up_taken = k[0];
            cycle();
        end
        up_valid = 1'b0;
        check("full_ready", 32'(up_ready), 32'd0);
        check("full_qcount", 32'(q_count), 32'd4);
        cycle();
        check("full_forced_gnt", 32'(obs_gnt), 32'd0);
        check("full_forced_rw", 32'(read_write), 32'd0);
        check("full_ready_back", 32'(up_ready), 32'd1);

        // Simultaneous push and pop leaves the count unchanged.
        lk_req = 1'b0;
        up_valid = 1'b1; up_inst = 24'h000040; up_taddr = 32'h200; up_taken = 1'b1;
        cycle();
        up_valid = 1'b0;
        check("pushpop_qcount", 32'(q_count), 32'd3);

        // Reset mid-operation with three queued updates.
        lk_req = 1'b1;
        do_reset();

        // Lookup against a queued update at the same index.
        lk_req = 1'b1; lk_inst = 24'h0003FF;
        up_valid = 1'b1; up_inst = 24'h000155; up_taddr = 32'h1234; up_taken = 1'b0;
        cycle();
        up_valid = 1'b0;
        lk_inst = 24'h123555;
        cycle();
`ifdef BPU_ARB_RAW_EN
        check("raw_deny", 32'(obs_gnt), 32'd0);
        check("raw_drain_rw", 32'(read_write), 32'd0);
        cycle();
        check("raw_grant", 32'(obs_gnt), 32'd1);
`else
        check("noraw_grant", 32'(obs_gnt), 32'd1);
`endif
        lk_req = 1'b0;
        cycle();

        // Randomized traffic with varying request/update pressure.
        p_req = 50; p_up = 30;
        for (int c = 0; c < 1200; c++) begin
            if (c == 600) do_reset();
            if (c % 64 == 0) begin
                p_req = $urandom_range(0, 100);
                p_up  = $urandom_range(0, 80);
            end
            if (!lk_req || m_gnt) begin
                lk_req  = ($urandom_range(0, 99) < p_req);
                lk_inst = rnd_inst();
                lk_cond = 1'($urandom_range(0, 1));
            end
            if (mq.size() < c_DEPTH && $urandom_range(0, 99) < p_up) begin
                up_valid = 1'b1;
                up_inst  = rnd_inst();
                up_taken = 1'($urandom_range(0, 1));
                up_taddr = $urandom;
            end else begin
                up_valid = 1'b0;
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
